pass_verify: RTL and testbench
==============================

// Module: pass_verify
// PURPOSE
//  Reader side of the 4-digit keypad password path. The entry logic writes and holds
//  the stored 16-bit password (4 nibbles, first digit in [15:12]).
//  This block takes a fresh keypad sequence and compares it against that stored value.
//  It drives unlock / fail / lockout status to the lock actuator and display logic.
// PARAMETERS
//  OPEN_CYCLES  default 8   clk cycles unlock stays high after a match (>=1)
//  MAX_TRIES    default 3   consecutive mismatches before lockout (1..7)
//  LOCK_CYCLES  default 16  clk cycles spent in LOCK (only with PASS_LOCKOUT_EN)
// PORTS
//  clk          in   1   system clock
//  rst          in   1   asynchronous, active-low reset
//  key_value    in   4   keypad code; 0-9 digits, 4'hA-4'hF ignored
//  key_en       in   1   keypad strobe level, synchronous to clk; rising edge = one key
//  cancel       in   1   synchronous; abandons the current entry
//  stored_pass  in   16  stored password, digit1 in [15:12] ... digit4 in [3:0]
//  unlock       out  1   high for OPEN_CYCLES after a correct entry
//  fail         out  1   one-cycle pulse on a wrong entry
//  locked       out  1   high while in LOCK
//  digit_cnt    out  3   digits accepted in the current entry (0-4)
//  err_cnt      out  3   consecutive failures, saturating at MAX_TRIES
//  entry_disp   out  16  entered digits left-justified as {d1,d2,d3,d4}; unentered nibbles 4'h0
// BEHAVIOUR
//  Reset (rst=0): state=IDLE; all outputs 0; entry register 0; edge-detect flop 0.
//  Key accept: key_rise = key_en & ~key_en_q (key_en_q is a registered copy).
//   - Accepted only if key_rise, key_value<=9, and state is IDLE or COLLECT.
//   - Accepted digit loads nibble [15-4*digit_cnt -: 4] of the entry register.
//   - The nibble and digit_cnt+1 become visible the next cycle.
//   - key_en held high gives exactly one key; a strobe with a code >9 changes nothing.
//  FSM:
//   - IDLE: first accepted digit -> COLLECT.
//   - COLLECT: the 4th accepted digit -> CHECK. cancel -> IDLE, entry and digit_cnt cleared.
//     cancel and a key in the same cycle: cancel wins, key dropped.
//   - CHECK (1 cycle): compare the entry with the stored_pass value sampled in this cycle.
//     Equal -> OPEN with err_cnt cleared. Unequal -> FAIL.
//   - OPEN: unlock=1 for exactly OPEN_CYCLES cycles, then IDLE. Keys and cancel ignored.
//   - FAIL (1 cycle): fail=1; err_cnt = min(err_cnt+1, MAX_TRIES). Then LOCK if
//     err_cnt reaches MAX_TRIES and PASS_LOCKOUT_EN is defined, else IDLE.
//  Latency: 4th key_rise at cycle N -> CHECK at N+1 -> unlock or fail asserted at N+2.
//  Entry register and digit_cnt clear on entering IDLE from CHECK/OPEN/FAIL/LOCK.
//  entry_disp equals the entry register (valid in IDLE/COLLECT/CHECK; 0 elsewhere).
//  stored_pass changing mid-entry has no effect until CHECK samples it.
//  rst asserted mid-operation: immediate return to the reset state. Partial entry and
//  err_cnt are lost; unlock drops asynchronously.
//  Counters: open/lock timers sized $clog2(max(OPEN_CYCLES,LOCK_CYCLES)+1); no wrap;
//  the timer reloads on state entry.
// CONFIGURATION
//  PASS_LOCKOUT_EN defined:
//   - FAIL with err_cnt==MAX_TRIES -> LOCK; locked=1 for LOCK_CYCLES cycles.
//   - All keys and cancel are ignored while locked.
//   - On exit to IDLE, err_cnt is cleared to 0.
//  PASS_LOCKOUT_EN undefined:
//   - No LOCK state; locked tied to 0.
//   - err_cnt saturates at MAX_TRIES and is cleared only by a successful match or reset.
// TESTING
//  stored 16'h1234, keys 1,2,3,4 -> unlock=1 two cycles after 4th key, for 8 cycles; err_cnt=0.
//  stored 16'h1234, keys 1,2,3,5 -> one fail pulse, err_cnt=1, state IDLE, entry_disp=0.
//  key_en held high 20 cycles with value 7 -> digit_cnt=1, entry_disp=16'h7000; key 4'hB -> no change.
//  keys 9,9 then cancel -> digit_cnt=0, entry_disp=0; next keys 1,2,3,4 (stored 1234) -> unlock.
//  EN: 3 wrong entries -> locked=1 16 cycles, keys ignored, then err_cnt=0; w/o EN: locked=0, err_cnt=3.
//  rst low during OPEN -> unlock=0 immediately, all outputs 0; normal entry works after release.

Source files
------------

// File: rtl/pass_verify.sv
// pass_verify: compares a 4-digit keypad entry against the stored password and drives unlock/fail/lockout status.
// Define PASS_LOCKOUT_EN to enter a timed LOCK state after MAX_TRIES consecutive failures.
module pass_verify #(
    parameter int OPEN_CYCLES = 8,
    parameter int MAX_TRIES   = 3,
    parameter int LOCK_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  key_value,
    input  logic        key_en,
    input  logic        cancel,
    input  logic [15:0] stored_pass,
    output logic        unlock,
    output logic        fail,
    output logic        locked,
    output logic [2:0]  digit_cnt,
    output logic [2:0]  err_cnt,
    output logic [15:0] entry_disp
);
    localparam int MAXC = OPEN_CYCLES > LOCK_CYCLES ? OPEN_CYCLES : LOCK_CYCLES;
    localparam int TW   = $clog2(MAXC + 1);

    typedef enum logic [2:0] {IDLE, COLLECT, CHECK, OPEN, FAILS, LOCK} state_t;

    state_t        state_q, state_d;
    logic          key_en_q;
    logic [15:0]   entry_q, entry_d;
    logic [2:0]    digit_q, digit_d;
    logic [2:0]    err_q, err_d;
    logic [TW-1:0] tmr_q, tmr_d;
    logic          unlock_q, unlock_d;
    logic          fail_q, fail_d;
    logic          locked_q, locked_d;
    logic          key_ok;

    assign key_ok = key_en & ~key_en_q & (key_value <= 4'd9);

    always_comb begin
        state_d  = state_q;
        entry_d  = entry_q;
        digit_d  = digit_q;
        err_d    = err_q;
        tmr_d    = tmr_q;
        unlock_d = unlock_q;
        fail_d   = 1'b0;
        locked_d = locked_q;
        case (state_q)
            IDLE, COLLECT: begin
                // cancel takes priority over a key strobe in the same cycle
                if (cancel) begin
                    state_d = IDLE;
                    entry_d = 16'h0;
                    digit_d = 3'd0;
                end else if (key_ok) begin
                    entry_d = entry_q | ({key_value, 12'h0} >> (4 * digit_q));
                    digit_d = digit_q + 3'd1;
                    state_d = digit_q == 3'd3 ? CHECK : COLLECT;
                end
            end
            CHECK: begin
                if (entry_q == stored_pass) begin
                    state_d  = OPEN;
                    err_d    = 3'd0;
                    unlock_d = 1'b1;
                    tmr_d    = TW'(OPEN_CYCLES - 1);
                end else begin
                    state_d = FAILS;
                    fail_d  = 1'b1;
                    err_d   = err_q >= 3'(MAX_TRIES) ? 3'(MAX_TRIES) : err_q + 3'd1;
                end
            end
            OPEN: begin
                if (tmr_q == '0) begin
                    state_d  = IDLE;
                    unlock_d = 1'b0;
                    entry_d  = 16'h0;
                    digit_d  = 3'd0;
                end else begin
                    tmr_d = tmr_q - 1'b1;
                end
            end
            FAILS: begin
                state_d = IDLE;
                entry_d = 16'h0;
                digit_d = 3'd0;
`ifdef PASS_LOCKOUT_EN
                if (err_q == 3'(MAX_TRIES)) begin
                    state_d  = LOCK;
                    locked_d = 1'b1;
                    tmr_d    = TW'(LOCK_CYCLES - 1);
                end
`endif
            end
            LOCK: begin
                if (tmr_q == '0) begin
                    state_d  = IDLE;
                    locked_d = 1'b0;
                    err_d    = 3'd0;
                end else begin
                    tmr_d = tmr_q - 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            key_en_q <= 1'b0;
            entry_q  <= 16'h0;
            digit_q  <= 3'd0;
            err_q    <= 3'd0;
            tmr_q    <= '0;
            unlock_q <= 1'b0;
            fail_q   <= 1'b0;
            locked_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            key_en_q <= key_en;
            entry_q  <= entry_d;
            digit_q  <= digit_d;
            err_q    <= err_d;
            tmr_q    <= tmr_d;
            unlock_q <= unlock_d;
            fail_q   <= fail_d;
            locked_q <= locked_d;
        end
    end

    assign unlock     = unlock_q;
    assign fail       = fail_q;
    assign locked     = locked_q;
    assign digit_cnt  = digit_q;
    assign err_cnt    = err_q;
    assign entry_disp = (state_q == IDLE || state_q == COLLECT || state_q == CHECK) ? entry_q : 16'h0;
endmodule

// File: tb/tb_pass_verify.sv
// tb_pass_verify: directed-vector bench for pass_verify; honours PASS_LOCKOUT_EN when defined.
module tb_pass_verify;
    logic        clk, rst, key_en, cancel, unlock, fail, locked;
    logic [3:0]  key_value;
    logic [15:0] stored_pass, entry_disp;
    logic [2:0]  digit_cnt, err_cnt;
    int          total, passed, n;

    pass_verify dut (
        .clk(clk), .rst(rst), .key_value(key_value), .key_en(key_en), .cancel(cancel),
        .stored_pass(stored_pass), .unlock(unlock), .fail(fail), .locked(locked),
        .digit_cnt(digit_cnt), .err_cnt(err_cnt), .entry_disp(entry_disp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic press(input logic [3:0] d);
        key_value = d;
        key_en = 1'b1;
        @(negedge clk);
        key_en = 1'b0;
        @(negedge clk);
    endtask

    task automatic enter4(input logic [15:0] code);
        press(code[15:12]);
        press(code[11:8]);
        press(code[7:4]);
        press(code[3:0]);
    endtask

    task automatic wait_open_end();
        for (int i = 0; i < 40 && unlock; i++) @(negedge clk);
        chk("open_end", 32'(unlock), 32'd0);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_unlock"}, 32'(unlock), 32'd0);
        chk({tag, "_fail"}, 32'(fail), 32'd0);
        chk({tag, "_locked"}, 32'(locked), 32'd0);
        chk({tag, "_dc"}, 32'(digit_cnt), 32'd0);
        chk({tag, "_err"}, 32'(err_cnt), 32'd0);
        chk({tag, "_disp"}, 32'(entry_disp), 32'd0);
    endtask

    initial begin
        total = 0; passed = 0;
        rst = 1'b0; key_en = 1'b0; key_value = 4'h0; cancel = 1'b0; stored_pass = 16'h1234;
        repeat (3) @(negedge clk);
        chk_zero("reset");
        rst = 1'b1;
        @(negedge clk);

        press(4'd1); press(4'd2); press(4'd3);
        chk("dc3", 32'(digit_cnt), 32'd3);
        chk("disp123", 32'(entry_disp), 32'h1230);
        key_value = 4'd4; key_en = 1'b1;
        @(negedge clk);
        chk("check_cyc_unlock", 32'(unlock), 32'd0);
        chk("check_cyc_disp", 32'(entry_disp), 32'h1234);
        key_en = 1'b0;
        @(negedge clk);
        chk("match_unlock", 32'(unlock), 32'd1);
        n = 0;
        while (unlock && n < 30) begin
            n++;
            @(negedge clk);
        end
        chk("open_len", 32'(n), 32'd8);
        chk("match_err", 32'(err_cnt), 32'd0);
        chk("after_open_disp", 32'(entry_disp), 32'd0);

        enter4(16'h1235);
        chk("wrong_fail", 32'(fail), 32'd1);
        chk("wrong_err", 32'(err_cnt), 32'd1);
        chk("wrong_unlock", 32'(unlock), 32'd0);
        @(negedge clk);
        chk("fail_pulse_end", 32'(fail), 32'd0);
        chk("wrong_disp", 32'(entry_disp), 32'd0);
        chk("wrong_dc", 32'(digit_cnt), 32'd0);

        key_value = 4'd7; key_en = 1'b1;
        repeat (20) @(negedge clk);
        key_en = 1'b0;
        @(negedge clk);
        chk("hold_dc", 32'(digit_cnt), 32'd1);
        chk("hold_disp", 32'(entry_disp), 32'h7000);
        press(4'hB);
        chk("bad_code_dc", 32'(digit_cnt), 32'd1);
        chk("bad_code_disp", 32'(entry_disp), 32'h7000);
        cancel = 1'b1;
        @(negedge clk);
        cancel = 1'b0;
        chk("cancel_dc", 32'(digit_cnt), 32'd0);
        chk("cancel_disp", 32'(entry_disp), 32'd0);
        press(4'd9); press(4'd9);
        chk("dc99", 32'(digit_cnt), 32'd2);
        chk("disp99", 32'(entry_disp), 32'h9900);
        key_value = 4'd5; key_en = 1'b1; cancel = 1'b1;
        @(negedge clk);
        key_en = 1'b0; cancel = 1'b0;
        @(negedge clk);
        chk("cancel_key_dc", 32'(digit_cnt), 32'd0);
        chk("cancel_key_disp", 32'(entry_disp), 32'd0);
        stored_pass = 16'hFFFF;
        press(4'd1); press(4'd2);
        stored_pass = 16'h1234;
        press(4'd3); press(4'd4);
        chk("late_stored_unlock", 32'(unlock), 32'd1);
        wait_open_end();

        for (int i = 1; i <= 2; i++) begin
            enter4(16'h1111);
            chk("try_err", 32'(err_cnt), 32'(i));
            @(negedge clk);
        end
        enter4(16'h1111);
        chk("try3_fail", 32'(fail), 32'd1);
        chk("try3_err", 32'(err_cnt), 32'd3);
        @(negedge clk);
`ifdef PASS_LOCKOUT_EN
        chk("lock_on", 32'(locked), 32'd1);
        n = 0;
        while (locked && n < 40) begin
            n++;
            if (n == 3) begin key_value = 4'd1; key_en = 1'b1; end
            if (n == 4) key_en = 1'b0;
            @(negedge clk);
        end
        chk("lock_len", 32'(n), 32'd16);
        chk("lock_key_dc", 32'(digit_cnt), 32'd0);
        chk("lock_exit_err", 32'(err_cnt), 32'd0);
`else
        chk("no_lock", 32'(locked), 32'd0);
        chk("no_lock_err", 32'(err_cnt), 32'd3);
        enter4(16'h1111);
        chk("sat_fail", 32'(fail), 32'd1);
        chk("sat_err", 32'(err_cnt), 32'd3);
        @(negedge clk);
`endif

        enter4(16'h1112);
        @(negedge clk);
        press(4'd5); press(4'd6);
        chk("partial_dc", 32'(digit_cnt), 32'd2);
        rst = 1'b0;
        #1;
        chk("rst_partial_dc", 32'(digit_cnt), 32'd0);
        chk("rst_partial_err", 32'(err_cnt), 32'd0);
        chk("rst_partial_disp", 32'(entry_disp), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        enter4(16'h1234);
        chk("pre_rst_unlock", 32'(unlock), 32'd1);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk_zero("rst_open");
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("post_rst_idle", 32'(unlock), 32'd0);
        enter4(16'h1234);
        chk("post_rst_unlock", 32'(unlock), 32'd1);
        wait_open_end();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
